apb_master_arbiter: RTL

//  Shares one APB master port between two requesters: req0 = AHB-side host bridge, req1 = config/boot loader.

---
 rtl/apb_master_arbiter_if.sv | 49 ++++
 rtl/apb_master_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter_if.sv
// Bus bundle for apb_master_arbiter: two requester channels plus the shared APB master port.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_master_arbiter_if #(
  parameter int NSLV = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [31:0]       req0_addr;
  logic              req0_write;
  logic [31:0]       req0_wdata;
  logic              resp0_valid;
  logic [31:0]       resp0_rdata;
  logic              resp0_err;

  logic              req1_valid;
  logic              req1_ready;
  logic [31:0]       req1_addr;
  logic              req1_write;
  logic [31:0]       req1_wdata;
  logic              resp1_valid;
  logic [31:0]       resp1_rdata;
  logic              resp1_err;

  logic [31:0]       paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [NSLV-1:0]   psel;
  logic              penable;
  logic [NSLV*32-1:0] prdata;
  logic [NSLV-1:0]   pready;

  modport master (
    input  req0_valid, req0_addr, req0_write, req0_wdata,
    output req0_ready, resp0_valid, resp0_rdata, resp0_err,
    input  req1_valid, req1_addr, req1_write, req1_wdata,
    output req1_ready, resp1_valid, resp1_rdata, resp1_err,
    output paddr, pwrite, pwdata, psel, penable,
    input  prdata, pready
  );

  modport slave (
    output req0_valid, req0_addr, req0_write, req0_wdata,
    input  req0_ready, resp0_valid, resp0_rdata, resp0_err,
    output req1_valid, req1_addr, req1_write, req1_wdata,
    input  req1_ready, resp1_valid, resp1_rdata, resp1_err,
    input  paddr, pwrite, pwdata, psel, penable,
    output prdata, pready
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin arbiter driving one APB master port with address decode to NSLV slaves.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
  parameter logic [31:0] BASE_ADDR   = 32'h00A0_0000,
  parameter int          NSLV        = 5,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                pclk,
  input  logic                preset,
  apb_master_arbiter_if.master bus
);

  // state    | meaning
  // S_IDLE   | no transfer; grant and latch a request
  // S_SETUP  | APB setup phase, psel high, penable low
  // S_ACCESS | APB access phase, wait for pready of selected slave
  // S_RESP   | one-cycle response pulse to the granted requester
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  if (NSLV < 1 || NSLV > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("apb_master_arbiter: unsupported NSLV or TIMEOUT_CYC");
  end

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            gnt_q, gnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [31:0]     paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [31:0]     pwdata_q, pwdata_d;
  logic [NSLV-1:0] psel_q, psel_d;
  logic            penable_q, penable_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            resp0_valid_q, resp0_valid_d;
  logic            resp1_valid_q, resp1_valid_d;
`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  logic            grant0, grant1;
  logic [31:0]     sel_addr, sel_wdata, off;
  logic            sel_write, dec_err;
  logic [2:0]      dec_idx;
  logic            sel_ready;
  logic [31:0]     sel_rdata;

  // Round robin: on contention the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == S_IDLE && !preset) begin
      if (bus.req0_valid && (!bus.req1_valid || last_q)) grant0 = 1'b1;
      else if (bus.req1_valid)                           grant1 = 1'b1;
    end
  end

  assign sel_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
  assign sel_write = grant1 ? bus.req1_write : bus.req0_write;
  assign sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
  assign off       = sel_addr - BASE_ADDR;
  assign dec_err   = (sel_addr < BASE_ADDR) || (off >= (32'(NSLV) << 16));
  assign dec_idx   = off[18:16];

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == 3'(i)) begin
        sel_ready = bus.pready[i];
        sel_rdata = bus.prdata[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    gnt_d         = gnt_q;
    idx_d         = idx_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        if (grant0 || grant1) begin
          gnt_d  = grant1;
          last_d = grant1;
          if (dec_err) begin
            state_d       = S_RESP;
            rdata_d       = '0;
            err_d         = 1'b1;
            resp0_valid_d = grant0;
            resp1_valid_d = grant1;
          end else begin
            state_d  = S_SETUP;
            idx_d    = dec_idx;
            paddr_d  = sel_addr;
            pwrite_d = sel_write;
            pwdata_d = sel_wdata;
            psel_d   = {{(NSLV-1){1'b0}}, 1'b1} << dec_idx;
          end
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      S_ACCESS: begin
        if (sel_ready) begin
          state_d       = S_RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rdata_d       = pwrite_q ? 32'h0 : sel_rdata;
          err_d         = 1'b0;
          resp0_valid_d = !gnt_q;
          resp1_valid_d = gnt_q;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          state_d       = S_RESP;
          psel_d        = '0;
          penable_d     = 1'b0;
          rdata_d       = '0;
          err_d         = 1'b1;
          resp0_valid_d = !gnt_q;
          resp1_valid_d = gnt_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= S_IDLE;
      last_q        <= 1'b1;
      gnt_q         <= 1'b0;
      idx_q         <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      gnt_q         <= gnt_d;
      idx_q         <= idx_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.resp0_valid = resp0_valid_q;
  assign bus.resp1_valid = resp1_valid_q;
  assign bus.resp0_rdata = resp0_valid_q ? rdata_q : 32'h0;
  assign bus.resp1_rdata = resp1_valid_q ? rdata_q : 32'h0;
  assign bus.resp0_err   = resp0_valid_q & err_q;
  assign bus.resp1_err   = resp1_valid_q & err_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;

endmodule
